// File: rtl/id_ex_stage_pkg.sv
// Shared types for the MIPS pipeline: the decoded control bundle layout and
// the all-zero bubble that squashes an instruction in flight.
package mips_pipe_pkg;

    localparam int CTRL_W = 10;

    localparam int CB_REG_WRITE  = 9;
    localparam int CB_MEM_TO_REG = 8;
    localparam int CB_MEM_READ   = 7;
    localparam int CB_MEM_WRITE  = 6;
    localparam int CB_ALU_SRC    = 5;
    localparam int CB_REG_DST    = 4;
    localparam int CB_BRANCH     = 3;
    localparam int CB_ALU_OP_LSB = 0;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, execute-side registered outputs
// and the upstream freeze controls.
interface id_ex_if
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              id_uses_rt;
    ctrl_t             id_ctrl;
    logic              ex_stall;
    logic              flush;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_br_target;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_dest;
    ctrl_t             ex_ctrl;
    logic              pc_write;
    logic              ifid_write;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, ex_stall, flush,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_br_target,
               ex_rs, ex_rt, ex_dest, ex_ctrl, pc_write, ifid_write, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, ex_stall, flush,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_br_target,
               ex_rs, ex_rt, ex_dest, ex_ctrl, pc_write, ifid_write, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and the PC / IF-ID write enables.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_stall_i,
    input  logic             flush_i,
    output logic             hazard_o,
    output logic             pc_write_o,
    output logic             ifid_write_o
);

    logic rt_nonzero;
    logic src_match;

    // $zero never carries a real dependency, so a load into it cannot stall.
    assign rt_nonzero = |ex_rt_i;
    assign src_match  = (ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i));
    assign hazard_o   = id_valid_i && ex_valid_i && ex_mem_read_i && rt_nonzero && src_match;

    // A flush must let the fetch redirect through even while stalled.
    assign pc_write_o   = !(hazard_o || ex_stall_i) || flush_i;
    assign ifid_write_o = pc_write_o;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, computes the
// branch target and write destination, and inserts bubbles on hazard/flush.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic    clk,
    input logic    rst_n,
    id_ex_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic              ex_valid_q,     ex_valid_d;
    ctrl_t             ex_ctrl_q,      ex_ctrl_d;
    logic [DATA_W-1:0] ex_pc4_q,       ex_pc4_d;
    logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
    logic [DATA_W-1:0] ex_br_target_q, ex_br_target_d;
    logic [REG_W-1:0]  ex_rs_q,        ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q,        ex_rt_d;
    logic [REG_W-1:0]  ex_dest_q,      ex_dest_d;
    logic [CNT_W-1:0]  bubble_cnt_q,   bubble_cnt_d;

    logic                     hazard;
    logic                     load_en;
    logic                     bubble;
    ctrl_t                    id_ctrl;
    logic signed [DATA_W-1:0] imm_x4;
    logic [DATA_W-1:0]        br_target;
    logic [REG_W-1:0]         dest;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_valid_i    (bus.id_valid),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q.mem_read),
        .ex_rt_i       (ex_rt_q),
        .ex_stall_i    (bus.ex_stall),
        .flush_i       (bus.flush),
        .hazard_o      (hazard),
        .pc_write_o    (bus.pc_write),
        .ifid_write_o  (bus.ifid_write)
    );

    assign id_ctrl = bus.id_ctrl;

    // Word offset: the shift drops imm[31:30] and the add wraps modulo 2^DATA_W.
    assign imm_x4    = $signed(bus.id_imm) <<< 2;
    assign br_target = bus.id_pc4 + $unsigned(imm_x4);
    assign dest      = id_ctrl.reg_dst ? bus.id_rd : bus.id_rt;

    // Flush beats stall; stall beats hazard. Bubbles still load the data fields.
    assign load_en = bus.flush || !bus.ex_stall;
    assign bubble  = bus.flush || (!bus.ex_stall && hazard);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_pc4_d       = ex_pc4_q;
        ex_rs_data_d   = ex_rs_data_q;
        ex_rt_data_d   = ex_rt_data_q;
        ex_imm_d       = ex_imm_q;
        ex_br_target_d = ex_br_target_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        bubble_cnt_d   = bubble_cnt_q;

        if (load_en) begin
            ex_pc4_d       = bus.id_pc4;
            ex_rs_data_d   = bus.id_rs_data;
            ex_rt_data_d   = bus.id_rt_data;
            ex_imm_d       = bus.id_imm;
            ex_br_target_d = br_target;
            ex_rs_d        = bus.id_rs;
            ex_rt_d        = bus.id_rt;
            ex_dest_d      = dest;
            if (bubble) begin
                ex_valid_d   = 1'b0;
                ex_ctrl_d    = BUBBLE_CTRL;
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end else begin
                ex_valid_d = bus.id_valid;
                ex_ctrl_d  = bus.id_valid ? id_ctrl : BUBBLE_CTRL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= BUBBLE_CTRL;
            ex_pc4_q       <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_br_target_q <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_pc4_q       <= ex_pc4_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_br_target_q <= ex_br_target_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_pc4       = ex_pc4_q;
    assign bus.ex_rs_data   = ex_rs_data_q;
    assign bus.ex_rt_data   = ex_rt_data_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_br_target = ex_br_target_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_dest      = ex_dest_q;
    assign bus.bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic scored
// against a transaction-level model of the ID/EX register.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    localparam logic [9:0] LW_CTRL  = 10'h3A0;
    localparam logic [9:0] ADD_CTRL = 10'h212;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model of what EX should hold.
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_pc4, m_rs_data, m_rt_data, m_imm, m_br;
    logic [4:0]  m_rs, m_rt, m_dest;
    int          m_cnt;

    logic [9:0] ex_ctrl_v;
    assign ex_ctrl_v = bus.ex_ctrl;

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; m_pc4 = '0; m_rs_data = '0; m_rt_data = '0;
        m_imm = '0; m_br = '0; m_rs = '0; m_rt = '0; m_dest = '0; m_cnt = 0;
    endtask

    function automatic logic model_hazard();
        return bus.id_valid && m_valid && m_ctrl[7] && (m_rt != 0) &&
               ((m_rt == bus.id_rs) || (bus.id_uses_rt && (m_rt == bus.id_rt)));
    endfunction

    function automatic logic model_pc_write();
        return !(model_hazard() || bus.ex_stall) || bus.flush;
    endfunction

    task automatic model_edge();
        logic       h;
        logic [9:0] c;
        h = model_hazard();
        c = bus.id_ctrl;
        if (bus.flush || !bus.ex_stall) begin
            m_pc4 = bus.id_pc4; m_rs_data = bus.id_rs_data; m_rt_data = bus.id_rt_data;
            m_imm = bus.id_imm; m_br = bus.id_pc4 + bus.id_imm * 32'd4;
            m_rs = bus.id_rs; m_rt = bus.id_rt;
            m_dest = c[4] ? bus.id_rd : bus.id_rt;
            if (bus.flush || h) begin
                m_valid = 0; m_ctrl = '0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_valid = bus.id_valid;
                m_ctrl  = bus.id_valid ? c : 10'h0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic uses_rt, input logic [9:0] c);
        bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_uses_rt = uses_rt; bus.id_ctrl = c;
        bus.id_pc4 = $urandom; bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
        bus.id_imm = $urandom;
    endtask

    task automatic test_reset();
        bus.ex_stall = 0; bus.flush = 0;
        drive_id(1, 5'd1, 5'd2, 5'd3, 1, ADD_CTRL);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.ex_valid); else n_pass++;
        n_checks++; if (bus.bubble_cnt !== 16'h0) $display("FAIL reset_cnt got=%h exp=0", bus.bubble_cnt); else n_pass++;
        rst_n = 1;
        tick();
        drive_id(1, 5'd4, 5'd6, 5'd7, 1, ADD_CTRL);
        tick();
        n_checks++; if (bus.ex_valid !== 1'b1) $display("FAIL pre_rst_valid got=%0b exp=1", bus.ex_valid); else n_pass++;
        // Asynchronous assertion mid-cycle with a live instruction in ID.
        rst_n = 0;
        #1;
        model_reset();
        n_checks++; if (bus.ex_valid !== 1'b0) $display("FAIL async_rst_valid got=%0b exp=0", bus.ex_valid); else n_pass++;
        n_checks++; if (ex_ctrl_v !== 10'h0) $display("FAIL async_rst_ctrl got=%h exp=0", ex_ctrl_v); else n_pass++;
        n_checks++; if ({bus.ex_pc4, bus.ex_imm, bus.ex_br_target, bus.ex_rs_data, bus.ex_rt_data} !== 160'h0)
            $display("FAIL async_rst_data got=%h exp=0", {bus.ex_pc4, bus.ex_imm, bus.ex_br_target, bus.ex_rs_data, bus.ex_rt_data}); else n_pass++;
        n_checks++; if ({bus.ex_rs, bus.ex_rt, bus.ex_dest} !== 15'h0) $display("FAIL async_rst_regs got=%h exp=0", {bus.ex_rs, bus.ex_rt, bus.ex_dest}); else n_pass++;
        #2;
        rst_n = 1;
        drive_id(1, 5'd0, 5'd0, 5'd0, 0, ADD_CTRL);
        bus.id_imm = 32'hFFFF_FFFC; bus.id_pc4 = 32'h0040_0010;
        tick();
        n_checks++; if (bus.ex_imm !== 32'hFFFF_FFFC) $display("FAIL first_imm got=%h exp=fffffffc", bus.ex_imm); else n_pass++;
        n_checks++; if (bus.ex_br_target !== 32'h0040_0000) $display("FAIL first_br_target got=%h exp=00400000", bus.ex_br_target); else n_pass++;
        n_checks++; if (bus.ex_valid !== 1'b1) $display("FAIL first_valid got=%0b exp=1", bus.ex_valid); else n_pass++;
    endtask

    task automatic test_load_use();
        int c0;
        drive_id(1, 5'd2, 5'd8, 5'd0, 0, LW_CTRL);
        tick();
        c0 = m_cnt;
        drive_id(1, 5'd8, 5'd3, 5'd10, 1, ADD_CTRL);
        #1;
        n_checks++; if (bus.pc_write !== 1'b0) $display("FAIL lu_pc_write got=%0b exp=0", bus.pc_write); else n_pass++;
        n_checks++; if (bus.ifid_write !== 1'b0) $display("FAIL lu_ifid_write got=%0b exp=0", bus.ifid_write); else n_pass++;
        tick();
        n_checks++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got=%0b exp=0", bus.ex_valid); else n_pass++;
        n_checks++; if (ex_ctrl_v !== 10'h0) $display("FAIL lu_bubble_ctrl got=%h exp=0", ex_ctrl_v); else n_pass++;
        n_checks++; if (int'(bus.bubble_cnt) !== c0 + 1) $display("FAIL lu_bubble_cnt got=%0d exp=%0d", bus.bubble_cnt, c0 + 1); else n_pass++;
        n_checks++; if (bus.pc_write !== 1'b1) $display("FAIL lu_release_pc_write got=%0b exp=1", bus.pc_write); else n_pass++;
        tick();
        n_checks++; if (bus.ex_valid !== 1'b1) $display("FAIL lu_add_valid got=%0b exp=1", bus.ex_valid); else n_pass++;
        n_checks++; if (ex_ctrl_v !== ADD_CTRL) $display("FAIL lu_add_ctrl got=%h exp=%h", ex_ctrl_v, ADD_CTRL); else n_pass++;
        n_checks++; if (bus.ex_dest !== 5'd10) $display("FAIL lu_add_dest got=%0d exp=10", bus.ex_dest); else n_pass++;
    endtask

    task automatic test_no_stall_cases();
        drive_id(1, 5'd1, 5'd0, 5'd0, 0, LW_CTRL);
        tick();
        drive_id(1, 5'd0, 5'd0, 5'd4, 1, ADD_CTRL);
        #1;
        n_checks++; if (bus.pc_write !== 1'b1) $display("FAIL zero_reg_pc_write got=%0b exp=1", bus.pc_write); else n_pass++;
        drive_id(1, 5'd1, 5'd9, 5'd0, 0, LW_CTRL);
        tick();
        n_checks++; if (bus.ex_valid !== 1'b1) $display("FAIL zero_reg_valid got=%0b exp=1", bus.ex_valid); else n_pass++;
        drive_id(1, 5'd4, 5'd9, 5'd0, 0, LW_CTRL);
        #1;
        n_checks++; if (bus.pc_write !== 1'b1) $display("FAIL unused_rt_pc_write got=%0b exp=1", bus.pc_write); else n_pass++;
        bus.id_uses_rt = 1;
        #1;
        n_checks++; if (bus.pc_write !== 1'b0) $display("FAIL used_rt_pc_write got=%0b exp=0", bus.pc_write); else n_pass++;
        bus.id_uses_rt = 0;
        tick();
        n_checks++; if (bus.ex_valid !== 1'b1) $display("FAIL unused_rt_valid got=%0b exp=1", bus.ex_valid); else n_pass++;
    endtask

    task automatic test_stall();
        int c0;
        logic [31:0] pc0, br0;
        drive_id(1, 5'd11, 5'd12, 5'd13, 1, ADD_CTRL);
        tick();
        c0 = m_cnt; pc0 = m_pc4; br0 = m_br;
        bus.ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 10'($urandom));
            #1;
            n_checks++; if (bus.pc_write !== 1'b0) $display("FAIL stall_pc_write[%0d] got=%0b exp=0", i, bus.pc_write); else n_pass++;
            tick();
            n_checks++; if ({bus.ex_pc4, bus.ex_br_target} !== {pc0, br0})
                $display("FAIL stall_hold_data[%0d] got=%h exp=%h", i, {bus.ex_pc4, bus.ex_br_target}, {pc0, br0}); else n_pass++;
            n_checks++; if ({bus.ex_valid, ex_ctrl_v, bus.ex_rs, bus.ex_rt, bus.ex_dest} !== {1'b1, ADD_CTRL, 5'd11, 5'd12, 5'd13})
                $display("FAIL stall_hold_ctl[%0d] got=%h exp=%h", i, {bus.ex_valid, ex_ctrl_v, bus.ex_rs, bus.ex_rt, bus.ex_dest},
                         {1'b1, ADD_CTRL, 5'd11, 5'd12, 5'd13}); else n_pass++;
            n_checks++; if (int'(bus.bubble_cnt) !== c0) $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", i, bus.bubble_cnt, c0); else n_pass++;
        end
        bus.ex_stall = 0;
    endtask

    task automatic test_flush_priority();
        int c0;
        drive_id(0, 5'd0, 5'd0, 5'd0, 0, 10'h0);
        tick();
        drive_id(1, 5'd1, 5'd8, 5'd0, 0, LW_CTRL);
        tick();
        c0 = m_cnt;
        drive_id(1, 5'd8, 5'd8, 5'd2, 1, ADD_CTRL);
        bus.ex_stall = 1; bus.flush = 1;
        #1;
        n_checks++; if (bus.pc_write !== 1'b1) $display("FAIL flush_pc_write got=%0b exp=1", bus.pc_write); else n_pass++;
        tick();
        n_checks++; if ({bus.ex_valid, ex_ctrl_v} !== 11'h0) $display("FAIL flush_bubble got=%h exp=0", {bus.ex_valid, ex_ctrl_v}); else n_pass++;
        n_checks++; if (int'(bus.bubble_cnt) !== c0 + 1) $display("FAIL flush_cnt got=%0d exp=%0d", bus.bubble_cnt, c0 + 1); else n_pass++;
        bus.ex_stall = 0; bus.flush = 0;
    endtask

    task automatic test_dest_select();
        drive_id(1, 5'd1, 5'd5, 5'd17, 1, ADD_CTRL);
        tick();
        n_checks++; if (bus.ex_dest !== 5'd17) $display("FAIL dest_rd got=%0d exp=17", bus.ex_dest); else n_pass++;
        drive_id(1, 5'd1, 5'd5, 5'd17, 0, 10'h220);
        tick();
        n_checks++; if (bus.ex_dest !== 5'd5) $display("FAIL dest_rt got=%0d exp=5", bus.ex_dest); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom), 1'($urandom), 10'($urandom));
            bus.ex_stall = ($urandom_range(0, 4) == 0);
            bus.flush    = ($urandom_range(0, 9) == 0);
            #1;
            n_checks++; if (bus.pc_write !== model_pc_write() || bus.ifid_write !== model_pc_write())
                $display("FAIL rnd_pc_write[%0d] got=%0b/%0b exp=%0b", i, bus.pc_write, bus.ifid_write, model_pc_write()); else n_pass++;
            tick();
            n_checks++; if ({bus.ex_valid, ex_ctrl_v} !== {m_valid, m_ctrl} || int'(bus.bubble_cnt) !== m_cnt)
                $display("FAIL rnd_ctl[%0d] got=%0b/%h/%0d exp=%0b/%h/%0d", i, bus.ex_valid, ex_ctrl_v, bus.bubble_cnt,
                         m_valid, m_ctrl, m_cnt); else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_br_target, bus.ex_rs, bus.ex_rt, bus.ex_dest} !==
                    {m_pc4, m_rs_data, m_rt_data, m_imm, m_br, m_rs, m_rt, m_dest})
                    $display("FAIL rnd_data[%0d] got=%h/%h/%0d exp=%h/%h/%0d", i, bus.ex_imm, bus.ex_br_target, bus.ex_dest,
                             m_imm, m_br, m_dest);
                else n_pass++;
            end
        end
        bus.ex_stall = 0; bus.flush = 0;
    endtask

    task automatic test_saturation();
        int guard = 0;
        bus.flush = 1;
        while (m_cnt < 'hFFFE && guard < 70000) begin
            tick();
            guard++;
        end
        n_checks++; if (bus.bubble_cnt !== 16'hFFFE) $display("FAIL sat_preload got=%h exp=fffe", bus.bubble_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.bubble_cnt !== 16'hFFFF) $display("FAIL sat_cnt[%0d] got=%h exp=ffff", i, bus.bubble_cnt); else n_pass++;
        end
        bus.flush = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall_cases();
        test_stall();
        test_flush_priority();
        test_dest_select();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute in the 5-stage MIPS core.
- Captures the 32-bit sign-extended immediate, the register-file read data, the register specifiers and the decoded control bundle.
- Computes the branch target and the write-destination register.
- Contains load-use hazard detection and inserts bubbles on hazard or branch flush.

Parameters:
- DATA_W, 32, datapath width (register data, immediate, PC).
- REG_W, 5, register specifier width.
- CNT_W, 16, bubble performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc4  in  DATA_W  PC+4 of the ID instruction.
- id_rs_data  in  DATA_W  register-file read port A.
- id_rt_data  in  DATA_W  register-file read port B.
- id_imm  in  DATA_W  sign-extended immediate from the sign-extension unit.
- id_rs, id_rt, id_rd  in  REG_W each  instruction register fields.
- id_uses_rt  in  1  instruction reads rt as a source.
- id_ctrl  in  CTRL_W  decoded control bundle (package layout).
- ex_stall  in  1  downstream EX/MEM cannot accept; hold everything.
- flush  in  1  branch taken in EX; squash the ID instruction.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered copies.
- ex_br_target  out  DATA_W  registered id_pc4 + (id_imm << 2).
- ex_rs, ex_rt  out  REG_W each  registered source specifiers (for forwarding).
- ex_dest  out  REG_W  registered reg_dst ? id_rd : id_rt.
- ex_ctrl  out  CTRL_W  registered control bundle.
- pc_write  out  1  combinational; 0 freezes the PC.
- ifid_write  out  1  combinational; 0 freezes IF/ID.
- bubble_cnt  out  CNT_W  number of bubbles inserted.

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including ex_valid, ex_ctrl and bubble_cnt. Release is synchronous to the next rising edge.
- Load-use hazard is combinational:
  - hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- pc_write = ifid_write = ~(hazard | ex_stall) | flush.
- Per rising edge, in priority order:
  1. flush=1: load a bubble. ex_valid=0 and ex_ctrl=0; data fields load normally (don't-care). Flush overrides ex_stall and hazard.
  2. ex_stall=1: hold every register unchanged; bubble_cnt unchanged.
  3. hazard=1: load a bubble as above.
  4. Otherwise: load all ID fields. ex_valid=id_valid; ex_ctrl=id_ctrl when id_valid, else 0.
- bubble_cnt increments by 1 on each bubble from case 1 or 3. It saturates at 2^CNT_W-1 and never wraps.
- ex_br_target: DATA_W-bit modulo addition; the shift discards id_imm[31:30].
- ex_dest comes from id_ctrl.reg_dst at load time. In a bubble it is don't-care, but ex_ctrl.reg_write=0 guarantees no writeback.
- Latency: 1 cycle ID to EX. Throughput: 1 instruction per cycle absent stalls.
- rst_n asserted mid-operation clears everything immediately. The in-flight instruction is lost, and the upstream PC is also reset.

Decomposition:
- Package mips_pipe_pkg holds:
  - CTRL_W = 10.
  - Control bundle bit positions: reg_write[9], mem_to_reg[8], mem_read[7], mem_write[6], alu_src[5], reg_dst[4], branch[3], alu_op[2:0].
  - A BUBBLE_CTRL constant of all zeros.
- One sub-module, hazard_detect: purely combinational. It produces hazard, pc_write and ifid_write.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with id_valid=1 → all outputs 0 immediately. After release, first edge loads ID: id_imm=0xFFFFFFFC, id_pc4=0x00400010 → ex_imm=0xFFFFFFFC, ex_br_target=0x00400000.
- Load-use: EX holds lw with mem_read=1, ex_rt=8; ID add with id_rs=8 → hazard=1, pc_write=0, ifid_write=0. Next edge: ex_valid=0, ex_ctrl=0, bubble_cnt=1. Following edge: add loads, ex_valid=1.
- Register 0 and unused rt: lw with ex_rt=0 and id_rs=0 → no stall. ex_rt=9 with id_rt=9 and id_uses_rt=0 → no stall.
- ex_stall: hold for 3 cycles with changing ID inputs → all ex_* unchanged, pc_write=0, bubble_cnt unchanged.
- flush together with ex_stall and hazard → bubble loaded, bubble_cnt+1, pc_write=1.
- Saturation: preload 0xFFFE bubbles, then 3 flushes → bubble_cnt=0xFFFF. Dest select: reg_dst=1, rd=17, rt=5 → ex_dest=17; reg_dst=0 → ex_dest=5.
